// File: rtl/conv_delay_fifo_pkg.sv
// Shared constants for the convolution-engine line delay buffer.
// Pixel width, default line delay, a constant clog2 and status flag positions.
package conv_buf_pkg;

    localparam int PIX_W      = 24;
    localparam int LINE_DELAY = 3 * 1927 + 1924 + 10;

    // Bit positions used when the status flags are exported as a vector
    localparam int FLAG_FULL   = 0;
    localparam int FLAG_EMPTY  = 1;
    localparam int FLAG_PRIMED = 2;
    localparam int FLAG_OVF    = 3;
    localparam int FLAG_N      = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/conv_delay_fifo_if.sv
// Valid/ready stream bundle on both sides of the line delay buffer.
// master = the environment around the buffer, slave = the buffer itself.
interface conv_delay_fifo_if #(
    parameter int DATA_W = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/conv_delay_fifo_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// The read register doubles as the buffer's output data register.
module sdp_ram #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Storage array write port, deliberately without reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; reset clears it, otherwise it holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/conv_delay_fifo.sv
// Line delay FIFO: holds pixels until a latched occupancy is reached, then streams
// them out; count includes the output register, full covers only the RAM array.
module conv_delay_fifo
    import conv_buf_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int DEPTH  = LINE_DELAY,
    parameter int CNT_W  = clog2(DEPTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [CNT_W-1:0]     delay_cfg,
    conv_delay_fifo_if.slave     bus,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic                 primed,
    output logic                 overflow_err
);
    localparam int               PTR_W    = clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  arr_cnt_r, count_r, delay_lat_r;
    logic              out_valid_r, full_r, empty_r, primed_r, ovf_r;

    logic              wr_en_s, ovf_hit_s, xfer_s, out_valid_next_s, primed_next_s;
    logic [CNT_W-1:0]  cfg_clamped_s, eff_lat_s, arr_next_s, count_next_s;
    logic [DATA_W-1:0] rd_data_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
    endfunction

    // Handshake decode, delay clamping and next occupancy
    always_comb begin
        wr_en_s          = bus.in_valid && !full_r && !flush && !rst;
        ovf_hit_s        = bus.in_valid && full_r && !flush;
        xfer_s           = primed_r && (arr_cnt_r != {CNT_W{1'b0}})
                           && (!out_valid_r || bus.out_ready) && !flush && !rst;
        cfg_clamped_s    = delay_cfg;
        if (delay_cfg == {CNT_W{1'b0}}) begin
            cfg_clamped_s = CNT_ONE;
        end else if (delay_cfg > DEPTH_C) begin
            cfg_clamped_s = DEPTH_C;
        end else begin
            cfg_clamped_s = delay_cfg;
        end
        // The threshold only follows delay_cfg while the buffer is empty
        eff_lat_s        = (count_r == {CNT_W{1'b0}}) ? cfg_clamped_s : delay_lat_r;
        arr_next_s       = arr_cnt_r;
        case ({wr_en_s, xfer_s})
            2'b10:   arr_next_s = arr_cnt_r + CNT_ONE;
            2'b01:   arr_next_s = arr_cnt_r - CNT_ONE;
            default: arr_next_s = arr_cnt_r;
        endcase
        if (xfer_s) begin
            out_valid_next_s = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_next_s = 1'b0;
        end else begin
            out_valid_next_s = out_valid_r;
        end
        count_next_s     = arr_next_s + {{(CNT_W-1){1'b0}}, out_valid_next_s};
        if (count_next_s == {CNT_W{1'b0}}) begin
            primed_next_s = 1'b0;
        end else begin
            primed_next_s = primed_r || (arr_next_s >= eff_lat_s);
        end
    end

    // Pointers, occupancy and status flags; reset and flush share the clear path
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            arr_cnt_r   <= {CNT_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            delay_lat_r <= CNT_ONE;
            out_valid_r <= 1'b0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            primed_r    <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (xfer_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            arr_cnt_r   <= arr_next_s;
            count_r     <= count_next_s;
            delay_lat_r <= eff_lat_s;
            out_valid_r <= out_valid_next_s;
            full_r      <= (arr_next_s == DEPTH_C);
            empty_r     <= (count_next_s == {CNT_W{1'b0}});
            primed_r    <= primed_next_s;
            ovf_r       <= ovf_r || ovf_hit_s;
        end
    end

    sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_en_s),
        .waddr  (wr_ptr_r),
        .wdata  (bus.in_data),
        .re     (xfer_s),
        .raddr  (rd_ptr_r),
        .rdata  (rd_data_s)
    );

    assign bus.in_ready  = !full_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = rd_data_s;
    assign count         = count_r;
    assign full          = full_r;
    assign empty         = empty_r;
    assign primed        = primed_r;
    assign overflow_err  = ovf_r;
endmodule

// File: tb/tb_conv_delay_fifo.sv
// Directed self-checking bench for conv_delay_fifo with DEPTH=16.
module tb_conv_delay_fifo;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;

    logic             clk = 1'b0;
    logic             rst, flush;
    logic [CNT_W-1:0] delay_cfg, count;
    logic             full, empty, primed, overflow_err;
    int               n_checks = 0;
    int               n_errors = 0;

    conv_delay_fifo_if #(.DATA_W(DATA_W)) bus ();

    conv_delay_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .delay_cfg    (delay_cfg),
        .bus          (bus.slave),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .primed       (primed),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_count"}, 32'(count), 32'd0);
        check_val({tag, "_empty"}, 32'(empty), 32'd1);
        check_val({tag, "_full"}, 32'(full), 32'd0);
        check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check_val({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check_val({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        check_val({tag, "_primed"}, 32'(primed), 32'd0);
        check_val({tag, "_ovf"}, 32'(overflow_err), 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; delay_cfg = 5'd4;
        bus.in_valid = 1'b0; bus.in_data = 24'h0; bus.out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_reset_state("reset");

        // Priming at delay 4
        for (int i = 1; i <= 3; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 24'(i);
            tick();
            check_val("prime_ov", 32'(bus.out_valid), 32'd0);
            check_val("prime_pr", 32'(primed), 32'd0);
        end
        bus.in_data = 24'h000004;
        tick();
        check_val("prime4_pr", 32'(primed), 32'd1);
        check_val("prime4_ov", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        check_val("first_ov", 32'(bus.out_valid), 32'd1);
        check_val("first_data", 32'(bus.out_data), 32'h000001);
        check_val("first_cnt", 32'(count), 32'd4);

        // Steady streaming: one in, one out per cycle, pointers wrap
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.in_data = 24'(5 + i);
            tick();
            check_val("stream_data", 32'(bus.out_data), 32'(2 + i));
            check_val("stream_ov", 32'(bus.out_valid), 32'd1);
            check_val("stream_cnt", 32'(count), 32'd4);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("drain_data", 32'(bus.out_data), 32'(42 + i));
        end
        tick();
        check_val("drain_ov", 32'(bus.out_valid), 32'd0);
        check_val("drain_empty", 32'(empty), 32'd1);
        check_val("drain_primed", 32'(primed), 32'd0);

        // Fill to full with delay 1 and a stalled output
        delay_cfg = 5'd1; bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            bus.in_data = 24'(100 + k);
            tick();
            check_val("fill_cnt", 32'(count), 32'(k));
            check_val("fill_full", 32'(full), (k == 17) ? 32'd1 : 32'd0);
        end
        check_val("full_in_ready", 32'(bus.in_ready), 32'd0);
        check_val("full_ovf_pre", 32'(overflow_err), 32'd0);
        bus.in_data = 24'd118;
        tick();
        check_val("ovf_set", 32'(overflow_err), 32'd1);
        check_val("ovf_cnt", 32'(count), 32'd17);
        bus.in_valid = 1'b0;
        tick();
        check_val("ovf_sticky", 32'(overflow_err), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check_val("unfull_data", 32'(bus.out_data), 32'd102);
        check_val("unfull_full", 32'(full), 32'd0);
        check_val("unfull_cnt", 32'(count), 32'd16);
        check_val("ovf_sticky2", 32'(overflow_err), 32'd1);

        // Flush clears, then nine words held and a flush with a concurrent write
        bus.out_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("flush1_cnt", 32'(count), 32'd0);
        check_val("flush1_ovf", 32'(overflow_err), 32'd0);
        bus.in_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            bus.in_data = 24'(200 + k);
            tick();
        end
        check_val("held9_cnt", 32'(count), 32'd9);
        bus.in_data = 24'h000055; flush = 1'b1;
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        check_val("flush2_cnt", 32'(count), 32'd0);
        check_val("flush2_empty", 32'(empty), 32'd1);
        check_val("flush2_ov", 32'(bus.out_valid), 32'd0);
        check_val("flush2_ovf", 32'(overflow_err), 32'd0);
        check_val("flush2_hold", 32'(bus.out_data), 32'd201);
        tick();
        check_val("flush_drop", 32'(count), 32'd0);
        bus.in_valid = 1'b1; bus.in_data = 24'hABCDEF;
        tick();
        bus.in_valid = 1'b0;
        check_val("abc_ov0", 32'(bus.out_valid), 32'd0);
        check_val("abc_cnt", 32'(count), 32'd1);
        tick();
        check_val("abc_ov1", 32'(bus.out_valid), 32'd1);
        check_val("abc_data", 32'(bus.out_data), 32'hABCDEF);
        bus.out_ready = 1'b1;
        tick();
        check_val("abc_empty", 32'(empty), 32'd1);

        // Delay change mid-stream is ignored until the buffer drains
        delay_cfg = 5'd4; bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            bus.in_data = 24'(300 + k);
            tick();
        end
        bus.in_valid = 1'b0;
        check_val("d5_cnt", 32'(count), 32'd5);
        check_val("d5_data", 32'(bus.out_data), 32'd301);
        delay_cfg = 5'd8; bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("d5_drain", 32'(bus.out_data), 32'(302 + k));
            check_val("d5_primed", 32'(primed), 32'd1);
        end
        tick();
        check_val("d5_empty", 32'(count), 32'd0);
        bus.in_valid = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            bus.in_data = 24'(400 + k);
            tick();
            check_val("d8_ov", 32'(bus.out_valid), 32'd0);
            check_val("d8_primed", 32'(primed), 32'd0);
        end
        bus.in_data = 24'd408;
        tick();
        bus.in_valid = 1'b0;
        check_val("d8_primed8", 32'(primed), 32'd1);
        tick();
        check_val("d8_ov1", 32'(bus.out_valid), 32'd1);
        check_val("d8_data", 32'(bus.out_data), 32'd401);
        check_val("d8_cnt", 32'(count), 32'd8);

        // Reset wins over write, read and flush in the same cycle
        rst = 1'b1; flush = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        bus.in_data = 24'h123456;
        tick();
        check_reset_state("rst_all");
        rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
        tick();
        check_reset_state("rst_after");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
